xgemac_wb_arbiter: RTL and testbench
====================================

# xgemac_wb_arbiter

Two-port Wishbone master arbiter for the XGEMAC register interface. It accepts single-word read/write commands from two on-chip requesters (port 0: configuration sequencer, port 1: statistics poller) and grants them round-robin onto the MAC's Wishbone slave port. It runs exactly one bus cycle at a time and returns read data, or a timeout error, to the requester that issued the command.

## Interface
Parameters:
- ADDR_W, 8, Wishbone address width (matches `XGEMAC_WB_ADDR_WIDTH`)
- DATA_W, 32, Wishbone data width (matches `XGEMAC_WB_DATA_WIDTH`)
- TIMEOUT, 255, maximum number of cycles to wait for wb_ack_o; legal range 1..65535

Ports:
- Clocking: one clock `clk`; reset `rst` is synchronous and active-low.
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous active-low reset
- req_valid  in  2  per-port command valid; held until req_ready
- req_we  in  2  per-port write enable (1 = write)
- req_adr  in  2*ADDR_W  per-port address; port n occupies bits [n*ADDR_W +: ADDR_W]
- req_dat  in  2*DATA_W  per-port write data, packed the same way
- req_ready  out  2  one-cycle accept pulse, one-hot
- rsp_valid  out  2  one-cycle completion pulse, one-hot, to the granted port
- rsp_dat  out  DATA_W  read data; valid only with rsp_valid; 0 for writes and timeouts
- rsp_err  out  1  timeout flag; valid only with rsp_valid
- wb_adr_i  out  ADDR_W  Wishbone address to MAC
- wb_dat_i  out  DATA_W  Wishbone write data to MAC
- wb_cyc_i, wb_stb_i, wb_we_i  out  1 each  Wishbone cycle, strobe, write
- wb_ack_o  in  1  Wishbone acknowledge from MAC
- wb_dat_o  in  DATA_W  Wishbone read data from MAC

## Operation
- All outputs are registered.
- Reset values:
  - req_ready, rsp_valid, rsp_dat, rsp_err, all wb_* outputs = 0
  - state = IDLE
  - last_grant = 1, so port 0 wins first
  - timeout counter = 0
- FSM IDLE:
  - If any req_valid is high, choose the port that is not last_grant when both are high; otherwise choose the single requesting port.
  - Latch that port's we, adr, dat. Pulse its req_ready. Drive cyc = stb = 1 with the latched we/adr/dat. Clear the counter. Go to BUS.
- FSM BUS:
  - cyc, stb, we, adr, dat are held stable.
  - On wb_ack_o = 1: capture wb_dat_o if read (else 0), set err = 0, drop cyc/stb/we, go to RESP.
  - Otherwise, when counter == TIMEOUT-1: set data = 0, err = 1, drop cyc/stb/we, go to RESP.
  - Otherwise, increment the counter (16-bit, saturating).
- FSM RESP:
  - Pulse rsp_valid[granted] with rsp_dat/rsp_err. Set last_grant = granted. Go to IDLE.
  - A new grant is not possible until the cycle after RESP.
- Boundary rules:
  - Ack and the terminal count in the same cycle: the ack wins and err = 0.
  - wb_ack_o in IDLE or RESP is ignored.
  - A requester dropping req_valid after req_ready has no effect on the issued cycle.
  - wb_adr_i and wb_dat_i return to 0 when cyc drops.
  - rst low in any state returns all outputs to their reset values at that edge. An in-flight Wishbone cycle is abandoned and no rsp_valid is issued for it.

## Timing
- Let T be the edge where the grant is taken, i.e. req_valid was sampled high in IDLE.
  - req_ready and cyc/stb are high during cycle T+1.
  - If ack is sampled at edge T+1+k (k ≥ 0), cyc/stb are low and rsp_valid is high during cycle T+2+k.
  - The next grant can occur at edge T+3+k.
- Zero-wait-state slave (ack at the first edge): 3-cycle request-to-request throughput.
- Timeout path: cyc/stb stay high for exactly TIMEOUT cycles, then rsp_valid with err = 1 one cycle later.

## Test plan
- Reset state: hold rst = 0 for 3 cycles with req_valid = 2'b11 -> all outputs 0; after release, the first grant is port 0.
- Port 0 writes 0xDEADBEEF to 0x0C, slave acks 1 cycle after stb -> wb_we_i = 1, adr = 0x0C, dat = 0xDEADBEEF held until ack; rsp_valid = 2'b01, rsp_err = 0, rsp_dat = 0.
- Port 1 reads 0x40, slave returns 0x12345678 after 4 wait states -> stb held 5 cycles; rsp_valid = 2'b10, rsp_dat = 0x12345678.
- Both ports hold req_valid continuously for 6 transactions -> grants alternate 0, 1, 0, 1, 0, 1; never two consecutive grants to one port.
- TIMEOUT = 8, slave never acks -> cyc high for exactly 8 cycles; rsp_err = 1, rsp_dat = 0; the next request is serviced normally.
- Ack on the terminal timeout cycle -> rsp_err = 0 with the ack data. Separately, rst asserted mid-BUS -> cyc drops at that edge and no rsp_valid follows.

Source files
------------

// File: rtl/xgemac_wb_arbiter.sv
// Round-robin two-port Wishbone master for the XGEMAC register port.
// One bus cycle in flight; each requester gets its own read data or timeout.
`timescale 1ns/1ps
module xgemac_wb_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_adr,
    input  logic [2*DATA_W-1:0]   req_dat,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_dat,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     wb_adr_i,
    output logic [DATA_W-1:0]     wb_dat_i,
    output logic                  wb_cyc_i,
    output logic                  wb_stb_i,
    output logic                  wb_we_i,
    input  logic                  wb_ack_o,
    input  logic [DATA_W-1:0]     wb_dat_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [15:0] TERM = 16'(TIMEOUT - 1);

    logic [1:0]        state;
    logic              last_grant;
    logic              grant;
    logic [15:0]       cnt;

    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_adr;
    logic [DATA_W-1:0] sel_dat;

    // Contention goes to the port that did not win last; otherwise the lone requester.
    always_comb begin
        pick = 1'b0;
        if (&req_valid)
            pick = ~last_grant;
        else
            pick = req_valid[1];
        sel_we  = pick ? req_we[1] : req_we[0];
        sel_adr = pick ? req_adr[ADDR_W +: ADDR_W] : req_adr[0 +: ADDR_W];
        sel_dat = pick ? req_dat[DATA_W +: DATA_W] : req_dat[0 +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            cnt        <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_dat    <= '0;
            rsp_err    <= 1'b0;
            wb_adr_i   <= '0;
            wb_dat_i   <= '0;
            wb_cyc_i   <= 1'b0;
            wb_stb_i   <= 1'b0;
            wb_we_i    <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            unique case (state)
                S_IDLE: begin
                    if (|req_valid) begin
                        grant     <= pick;
                        req_ready <= pick ? 2'b10 : 2'b01;
                        wb_cyc_i  <= 1'b1;
                        wb_stb_i  <= 1'b1;
                        wb_we_i   <= sel_we;
                        wb_adr_i  <= sel_adr;
                        wb_dat_i  <= sel_dat;
                        cnt       <= '0;
                        state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    // Ack takes priority over the terminal count.
                    if (wb_ack_o) begin
                        rsp_dat   <= wb_we_i ? '0 : wb_dat_o;
                        rsp_err   <= 1'b0;
                        rsp_valid <= grant ? 2'b10 : 2'b01;
                        wb_cyc_i  <= 1'b0;
                        wb_stb_i  <= 1'b0;
                        wb_we_i   <= 1'b0;
                        wb_adr_i  <= '0;
                        wb_dat_i  <= '0;
                        state     <= S_RESP;
                    end else if (cnt == TERM) begin
                        rsp_dat   <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= grant ? 2'b10 : 2'b01;
                        wb_cyc_i  <= 1'b0;
                        wb_stb_i  <= 1'b0;
                        wb_we_i   <= 1'b0;
                        wb_adr_i  <= '0;
                        wb_dat_i  <= '0;
                        state     <= S_RESP;
                    end else if (cnt != 16'hFFFF) begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    rsp_dat    <= '0;
                    rsp_err    <= 1'b0;
                    last_grant <= grant;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xgemac_wb_arbiter.sv
// Scoreboard bench for xgemac_wb_arbiter with a wait-state programmable slave.
`timescale 1ns/1ps
module tb_xgemac_wb_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic [1:0]  vld;
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [15:0] req_adr;
    logic [63:0] req_dat;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [7:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic        wb_ack_o = 1'b0;
    logic [31:0] wb_dat_o = '0;

    int checks = 0;
    int failures = 0;

    rsp_t exp_q[$];
    rsp_t obs_q[$];
    int   grant_q[$];
    time  grant_t[$];

    logic [31:0] mem [256];
    int   waits = 0;
    bit   never_ack = 1'b0;
    int   ws_cnt = 0;

    logic        prev_cyc = 1'b0;
    logic [41:0] prev_bus = '0;
    int   cyc_len = 0;
    int   last_len = 0;
    int   hold_bad_cnt = 0;

    xgemac_wb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_dat(rsp_dat), .rsp_err(rsp_err),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want done");
        $fatal(1);
    end

    // Slave: ack on the (waits+1)-th cycle of a strobe unless never_ack.
    always @(negedge clk) begin
        if (wb_cyc_i && wb_stb_i) begin
            ws_cnt <= ws_cnt + 1;
            if (!never_ack && ws_cnt == waits) begin
                wb_ack_o <= 1'b1;
                wb_dat_o <= mem[wb_adr_i];
            end else begin
                wb_ack_o <= 1'b0;
                wb_dat_o <= '0;
            end
        end else begin
            ws_cnt   <= 0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end
    end

    always @(negedge clk) begin
        if (wb_cyc_i) begin
            if (prev_cyc && {wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i} !== prev_bus)
                hold_bad_cnt <= hold_bad_cnt + 1;
            cyc_len <= cyc_len + 1;
        end else if (prev_cyc) begin
            last_len <= cyc_len;
            cyc_len  <= 0;
        end
        prev_cyc <= wb_cyc_i;
        prev_bus <= {wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i};
        if (rsp_valid != 2'b00)
            obs_q.push_back({rsp_valid, rsp_dat, rsp_err});
        if (req_ready != 2'b00) begin
            grant_q.push_back(req_ready[1] ? 1 : 0);
            grant_t.push_back($time);
        end
    end

    task automatic set_req(input int p, input logic we,
                           input logic [7:0] adr, input logic [31:0] dat);
        req_we[p]          = we;
        req_adr[p*8 +: 8]  = adr;
        req_dat[p*32 +: 32] = dat;
        req_valid[p]       = 1'b1;
    endtask

    task automatic wait_ready(input int p, output bit to);
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (req_ready[p]) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output rsp_t r, output bit to);
        to = 1'b1;
        r  = '0;
        for (int i = 0; i < 60; i++) begin
            if (obs_q.size() > 0) begin
                r  = obs_q.pop_front();
                to = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rsp_t r, e;
        bit to;
        rst = 1'b0;
        set_req(0, 1'b1, 8'h01, 32'h1111_1111);
        set_req(1, 1'b0, 8'h02, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({req_ready, rsp_valid, rsp_dat, rsp_err, wb_adr_i, wb_dat_i,
                 wb_cyc_i, wb_stb_i, wb_we_i} !== 80'h0) begin
                failures++;
                $display("FAIL reset_outputs: got ready=%b rsp=%b cyc=%b adr=%h want all 0",
                         req_ready, rsp_valid, wb_cyc_i, wb_adr_i);
            end
        end
        rst = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (req_ready != 2'b00) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to || req_ready !== 2'b01) begin
            failures++;
            $display("FAIL first_grant: got %b want 01", req_ready);
        end
        req_valid = 2'b00;
        exp_q.push_back({2'b01, 32'h0, 1'b0});
        wait_rsp(r, to);
        e = exp_q.pop_front();
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL reset_first_rsp: got %h want %h", r, e);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_write();
        rsp_t r, e;
        bit to;
        int h0;
        waits = 1;
        h0 = hold_bad_cnt;
        set_req(0, 1'b1, 8'h0C, 32'hDEAD_BEEF);
        wait_ready(0, to);
        req_valid[0] = 1'b0;
        checks++;
        if (to || {wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i}
                  !== {3'b111, 8'h0C, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL write_bus: got cyc=%b stb=%b we=%b adr=%h dat=%h want 1 1 1 0c deadbeef",
                     wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i);
        end
        exp_q.push_back({2'b01, 32'h0, 1'b0});
        wait_rsp(r, to);
        e = exp_q.pop_front();
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL write_rsp: got %h want %h", r, e);
        end
        checks++;
        if (last_len !== 2 || hold_bad_cnt !== h0) begin
            failures++;
            $display("FAIL write_cycle: got len=%0d holdbad=%0d want len=2 holdbad=%0d",
                     last_len, hold_bad_cnt, h0);
        end
        checks++;
        if ({wb_cyc_i, wb_stb_i, wb_adr_i, wb_dat_i} !== 42'h0) begin
            failures++;
            $display("FAIL write_bus_idle: got adr=%h dat=%h cyc=%b want 0",
                     wb_adr_i, wb_dat_i, wb_cyc_i);
        end
    endtask

    task automatic test_read();
        rsp_t r, e;
        bit to;
        waits = 4;
        mem[8'h40] = 32'h1234_5678;
        set_req(1, 1'b0, 8'h40, 32'h0);
        wait_ready(1, to);
        req_valid[1] = 1'b0;
        checks++;
        if (to || {wb_cyc_i, wb_we_i, wb_adr_i} !== {2'b10, 8'h40}) begin
            failures++;
            $display("FAIL read_bus: got cyc=%b we=%b adr=%h want 1 0 40",
                     wb_cyc_i, wb_we_i, wb_adr_i);
        end
        exp_q.push_back({2'b10, 32'h1234_5678, 1'b0});
        wait_rsp(r, to);
        e = exp_q.pop_front();
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL read_rsp: got %h want %h", r, e);
        end
        checks++;
        if (last_len !== 5) begin
            failures++;
            $display("FAIL read_stb_len: got %0d want 5", last_len);
        end
    endtask

    task automatic test_back_to_back();
        rsp_t r, e;
        bit to;
        int g;
        waits = 0;
        mem[8'h10] = 32'h1010_AAAA;
        mem[8'h20] = 32'h2020_BBBB;
        grant_q.delete();
        grant_t.delete();
        set_req(0, 1'b0, 8'h10, 32'h0);
        set_req(1, 1'b0, 8'h20, 32'h0);
        for (int i = 0; i < 6; i++)
            exp_q.push_back((i % 2) == 0 ? {2'b01, 32'h1010_AAAA, 1'b0}
                                         : {2'b10, 32'h2020_BBBB, 1'b0});
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (grant_q.size() >= 6) break;
        end
        req_valid = 2'b00;
        for (int i = 0; i < 6; i++) begin
            g = (i < grant_q.size()) ? grant_q[i] : -1;
            checks++;
            if (g !== (i % 2)) begin
                failures++;
                $display("FAIL b2b_grant%0d: got %0d want %0d", i, g, i % 2);
            end
        end
        checks++;
        if (grant_t.size() < 6 || (grant_t[5] - grant_t[0]) !== 150) begin
            failures++;
            $display("FAIL b2b_throughput: got %0d grants want 6 spaced 150ns",
                     grant_t.size());
        end
        for (int i = 0; i < 6; i++) begin
            wait_rsp(r, to);
            e = exp_q.pop_front();
            checks++;
            if (to || r !== e) begin
                failures++;
                $display("FAIL b2b_rsp%0d: got %h want %h", i, r, e);
            end
        end
    endtask

    task automatic test_timeout();
        rsp_t r, e;
        bit to;
        never_ack = 1'b1;
        set_req(0, 1'b0, 8'h33, 32'h0);
        wait_ready(0, to);
        req_valid[0] = 1'b0;
        exp_q.push_back({2'b01, 32'h0, 1'b1});
        wait_rsp(r, to);
        e = exp_q.pop_front();
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL timeout_rsp: got %h want %h", r, e);
        end
        checks++;
        if (last_len !== TIMEOUT) begin
            failures++;
            $display("FAIL timeout_cyc_len: got %0d want %0d", last_len, TIMEOUT);
        end
        never_ack = 1'b0;
        waits = 2;
        mem[8'h44] = 32'hCAFE_F00D;
        set_req(1, 1'b0, 8'h44, 32'h0);
        wait_ready(1, to);
        req_valid[1] = 1'b0;
        exp_q.push_back({2'b10, 32'hCAFE_F00D, 1'b0});
        wait_rsp(r, to);
        e = exp_q.pop_front();
        checks++;
        if (to || r !== e || last_len !== 3) begin
            failures++;
            $display("FAIL after_timeout_rsp: got %h len=%0d want %h len=3",
                     r, last_len, e);
        end
    endtask

    task automatic test_ack_terminal();
        rsp_t r, e;
        bit to;
        waits = TIMEOUT - 1;
        mem[8'h55] = 32'h0BAD_C0DE;
        set_req(0, 1'b0, 8'h55, 32'h0);
        wait_ready(0, to);
        req_valid[0] = 1'b0;
        exp_q.push_back({2'b01, 32'h0BAD_C0DE, 1'b0});
        wait_rsp(r, to);
        e = exp_q.pop_front();
        checks++;
        if (to || r !== e || last_len !== TIMEOUT) begin
            failures++;
            $display("FAIL ack_terminal: got %h len=%0d want %h len=%0d",
                     r, last_len, e, TIMEOUT);
        end
    endtask

    task automatic test_reset_mid_bus();
        rsp_t r, e;
        bit to;
        never_ack = 1'b1;
        set_req(1, 1'b1, 8'h66, 32'hABCD_0123);
        wait_ready(1, to);
        req_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (to || wb_cyc_i !== 1'b1) begin
            failures++;
            $display("FAIL midbus_active: got cyc=%b want 1", wb_cyc_i);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_dat, rsp_err, wb_adr_i, wb_dat_i,
             wb_cyc_i, wb_stb_i, wb_we_i} !== 80'h0) begin
            failures++;
            $display("FAIL midbus_reset: got cyc=%b adr=%h dat=%h want all 0",
                     wb_cyc_i, wb_adr_i, wb_dat_i);
        end
        rst = 1'b1;
        never_ack = 1'b0;
        waits = 0;
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL midbus_no_rsp: got %0d responses want 0", obs_q.size());
        end
        mem[8'h70] = 32'h7070_0707;
        set_req(0, 1'b0, 8'h70, 32'h0);
        set_req(1, 1'b0, 8'h71, 32'h0);
        to = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (req_ready != 2'b00) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to || req_ready !== 2'b01) begin
            failures++;
            $display("FAIL midbus_regrant: got %b want 01", req_ready);
        end
        req_valid = 2'b00;
        exp_q.push_back({2'b01, 32'h7070_0707, 1'b0});
        wait_rsp(r, to);
        e = exp_q.pop_front();
        checks++;
        if (to || r !== e) begin
            failures++;
            $display("FAIL midbus_regrant_rsp: got %h want %h", r, e);
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_adr   = '0;
        req_dat   = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_timeout();
        test_ack_terminal();
        test_reset_mid_bus();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
